// File: rtl/mux_n_rr.sv
// rtl/mux_n_rr.sv - N-channel registered valid/ready multiplexer with manual or round-robin select
//
// Optional feature macro: MUX_N_SEL_ERR_EN (adds sticky sel_err output)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-high
//   mode       0 = manual select via sel, 1 = round-robin arbitration
//   sel        manual channel select (ignored in round-robin mode)
//   in_data    N packed words, channel k at [k*W +: W]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, at most one bit high
//   out_data   registered selected word
//   out_valid  out_data holds an unconsumed word
//   out_ready  consumer ready
//   out_ch     channel index that produced out_data
//   sel_err    (MUX_N_SEL_ERR_EN only) sticky flag: manual select was out of range
module mux_n_rr #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int SELW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SELW-1:0] out_ch
`ifdef MUX_N_SEL_ERR_EN
  ,
  output logic            sel_err
`endif
);

  // N widened by one bit so the range check never truncates when 2**SELW == N.
  localparam logic [SELW:0]   N_VAL    = (SELW+1)'(N);
  // Pointer resets to the last channel so the first search begins at channel 0.
  localparam logic [SELW-1:0] LAST_RST = SELW'(N - 1);

  logic [W-1:0]    out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic [SELW-1:0] out_ch_q, out_ch_d;
  logic [SELW-1:0] last_q, last_d;

  logic            sel_ok;
  logic            man_req;
  logic            rr_hi_found, rr_lo_found, rr_found;
  logic [SELW-1:0] rr_hi_g, rr_lo_g, rr_g;
  logic            grant_ok;
  logic [SELW-1:0] g;
  logic            can_load;
  logic            xfer;
  logic [W-1:0]    g_data;

  // Manual path: range check and the valid of the selected channel.
  always_comb begin
    sel_ok  = ({1'b0, sel} < N_VAL);
    man_req = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (sel == SELW'(k)) begin
        man_req = in_valid[k];
      end
    end
  end

  // Round-robin search split into two halves: the lowest requester above the
  // pointer wins; if none, the lowest requester at or below it wraps around.
  // Scanning downward lets the last hit in each half be the lowest index.
  always_comb begin
    rr_hi_found = 1'b0;
    rr_hi_g     = '0;
    rr_lo_found = 1'b0;
    rr_lo_g     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (in_valid[k]) begin
        if (SELW'(k) > last_q) begin
          rr_hi_found = 1'b1;
          rr_hi_g     = SELW'(k);
        end else begin
          rr_lo_found = 1'b1;
          rr_lo_g     = SELW'(k);
        end
      end
    end
    rr_found = rr_hi_found | rr_lo_found;
    rr_g     = rr_hi_found ? rr_hi_g : rr_lo_g;
  end

  // Grant selection. grant_ok already implies in_valid[g], so any ready we
  // raise is a completed transfer.
  always_comb begin
    can_load = !out_valid_q | out_ready;
    if (mode) begin
      grant_ok = rr_found;
      g        = rr_g;
    end else begin
      grant_ok = sel_ok & man_req;
      g        = sel;
    end
    xfer = grant_ok & can_load;
  end

  always_comb begin
    in_ready = '0;
    g_data   = '0;
    for (int k = 0; k < N; k++) begin
      if (g == SELW'(k)) begin
        in_ready[k] = xfer;
        g_data      = in_data[k*W +: W];
      end
    end
  end

  // Output register and pointer next-state. A load wins over a drain, which
  // gives back-to-back words at one per cycle.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    last_d      = last_q;
    if (xfer) begin
      out_data_d  = g_data;
      out_ch_d    = g;
      out_valid_d = 1'b1;
      if (mode) begin
        last_d = g;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      last_q      <= LAST_RST;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      last_q      <= last_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;

`ifdef MUX_N_SEL_ERR_EN
  logic sel_err_q, sel_err_d;

  // Sticky until reset; records any edge seen with an out-of-range manual select.
  always_comb begin
    sel_err_d = sel_err_q | (!mode & !sel_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_mux_n_rr.sv
// tb/tb_mux_n_rr.sv - randomized and directed self-checking bench for mux_n_rr
module tb_mux_n_rr;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int SELW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            mode;
  logic [SELW-1:0] sel;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [SELW-1:0] out_ch;

  logic            mode3;
  logic [1:0]      sel3;
  logic [23:0]     data3;
  logic [2:0]      valid3;
  logic [2:0]      ready3;
  logic [7:0]      out_data3;
  logic            out_valid3;
  logic            out_ready3;
  logic [1:0]      out_ch3;

`ifdef MUX_N_SEL_ERR_EN
  logic            sel_err;
  logic            sel_err3;
`endif

  always #5 clk = ~clk;

  mux_n_rr #(.N(N), .W(W), .SELW(SELW)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch)
`ifdef MUX_N_SEL_ERR_EN
    ,
    .sel_err   (sel_err)
`endif
  );

  mux_n_rr #(.N(3), .W(8), .SELW(2)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode3),
    .sel       (sel3),
    .in_data   (data3),
    .in_valid  (valid3),
    .in_ready  (ready3),
    .out_data  (out_data3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .out_ch    (out_ch3)
`ifdef MUX_N_SEL_ERR_EN
    ,
    .sel_err   (sel_err3)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the output register contents and the round-robin pointer,
  // kept as plain integers.
  logic       m_valid;
  logic [7:0] m_data;
  int         m_ch;
  int         m_last;
  logic [3:0] er;
  int         gk;

  // Which channel is ready this cycle: consumer must be able to accept; manual
  // picks sel if in range and requesting; round-robin walks last+1, last+2, ...
  function automatic logic [3:0] model_ready(input logic md, input int s, input logic [3:0] v,
                                             input logic ov, input logic ordy, input int lst);
    logic [3:0] r;
    r = 4'b0;
    if (ov && !ordy) return r;
    if (!md) begin
      if (s < N && v[s]) r[s] = 1'b1;
      return r;
    end
    for (int off = 1; off <= N; off++) begin
      int k;
      k = (lst + off) % N;
      if (v[k]) begin
        r[k] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_ch    = 0;
      m_last  = N - 1;
    end else begin
      er = model_ready(mode, int'(sel), in_valid, m_valid, out_ready, m_last);
      chk("cyc_in_ready", in_ready, er);
      chk("cyc_out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("cyc_out_data", out_data, m_data);
        chk("cyc_out_ch", out_ch, m_ch);
      end
      if (er != 4'b0) begin
        gk = 0;
        for (int k = 0; k < N; k++) if (er[k]) gk = k;
        m_data  = in_data[gk*W +: W];
        m_ch    = gk;
        m_valid = 1'b1;
        if (mode) m_last = gk;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  int rr_seq[6] = '{0, 1, 3, 0, 1, 3};
  int ms_seq[5] = '{0, 1, 3, 3, 2};

  initial begin
    rst       = 1'b1;
    mode      = 1'b0;
    sel       = 2'd2;
    in_data   = 32'hA3A2A1A0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    mode3      = 1'b0;
    sel3       = 2'd0;
    data3      = 24'hC2C1C0;
    valid3     = 3'b000;
    out_ready3 = 1'b1;

    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    rst = 1'b0;

    // Manual select of channel 2 with everyone requesting.
    #1;
    chk("man_in_ready", in_ready, 4'b0100);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("man_out_data", out_data, 8'hA2);
      chk("man_out_ch", out_ch, 2);
      chk("man_out_valid", out_valid, 1);
    end

    // Round-robin fairness: channel 2 idle, grants cycle 0,1,3.
    mode     = 1'b1;
    in_valid = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr_out_ch", out_ch, rr_seq[i]);
      chk("rr_out_data", out_data, 8'hA0 + rr_seq[i]);
    end

    // Backpressure: held word stable, no input ready.
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", in_ready, 4'b0000);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, 8'hA3);
      chk("bp_out_ch", out_ch, 3);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 4'b0001);
    tick();
    chk("bp_reload_ch", out_ch, 0);
    chk("bp_reload_valid", out_valid, 1);

    // Reset during a stall drops the held word without waiting for an edge.
    out_ready = 1'b0;
    tick();
    chk("stall_pre_rst_valid", out_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_data", out_data, 0);
    chk("async_rst_ch", out_ch, 0);
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    mode      = 1'b1;
    in_valid  = 4'b1111;

    // Mode switch: RR 0,1 -> manual 3,3 -> RR resumes after the preserved pointer.
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        mode = 1'b0;
        sel  = 2'd3;
      end
      if (i == 4) mode = 1'b1;
      tick();
      chk("ms_out_ch", out_ch, ms_seq[i]);
      chk("ms_out_data", out_data, 8'hA0 + ms_seq[i]);
    end

    // Out-of-range manual select on a 3-channel instance.
    sel3   = 2'd3;
    valid3 = 3'b111;
    #1;
    chk("bad_sel_ready", ready3, 3'b000);
`ifdef MUX_N_SEL_ERR_EN
    chk("sel_err_pre", sel_err3, 0);
`endif
    tick();
    chk("bad_sel_no_load", out_valid3, 0);
`ifdef MUX_N_SEL_ERR_EN
    chk("sel_err_set", sel_err3, 1);
`endif
    sel3 = 2'd0;
    #1;
    chk("good_sel_ready", ready3, 3'b001);
    tick();
    chk("good_sel_valid", out_valid3, 1);
    chk("good_sel_ch", out_ch3, 0);
    chk("good_sel_data", out_data3, 8'hC0);
`ifdef MUX_N_SEL_ERR_EN
    chk("sel_err_sticky", sel_err3, 1);
`endif
    valid3 = 3'b000;

    // Randomized traffic checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      mode      = ($urandom_range(0, 3) != 0);
      sel       = SELW'($urandom_range(0, 3));
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

`ifdef MUX_N_SEL_ERR_EN
    chk("sel_err_main_clear", sel_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
